// File: rtl/fetch_stage_if.sv
// Fetch-stage handshake bundle: hazard/redirect inputs, instruction-memory port,
// the IF/ID register outputs and the performance counters.
interface fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc_plus4;
  logic             if_id_valid;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] stall_count;

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
           fetch_count, flush_count, stall_count
  );

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
           fetch_count, flush_count, stall_count
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register, stall/flush handling
// and fetch/flush/stall event counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic           clk,
  input  logic           reset,
  fetch_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_STALL,
    ACT_FLUSH
  } action_e;

  action_e          action;
  logic [31:0]      redirect_pc;
  logic [31:0]      pc_plus4;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign pc_plus4 = pc_q + 32'd4;

  // Stall outranks redirects because branch operands are stale while the
  // pipeline is held; branch outranks jump.
  always_comb begin
    action      = ACT_FETCH;
    redirect_pc = bus.jump_target & ~32'h3;
    if (bus.stall) begin
      action = ACT_STALL;
    end else if (bus.branch_taken) begin
      action      = ACT_FLUSH;
      redirect_pc = bus.branch_target & ~32'h3;
    end else if (bus.jump) begin
      action = ACT_FLUSH;
    end
  end

  // NOTE: every always_comb output is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (action)
      ACT_STALL: begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      ACT_FLUSH: begin
        // The word fetched this cycle is dropped: there is no delay slot.
        pc_d        = redirect_pc;
        instr_d     = NOP_INSTR;
        pc_plus4_d  = pc_plus4;
        valid_d     = 1'b0;
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
      default: begin
        pc_d        = pc_plus4;
        instr_d     = bus.imem_data;
        pc_plus4_d  = pc_plus4;
        valid_d     = 1'b1;
        fetch_cnt_d = fetch_cnt_q + 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_plus4_q  <= 32'h0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_plus4_q  <= pc_plus4_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc_plus4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.fetch_count    = fetch_cnt_q;
  assign bus.flush_count    = flush_cnt_q;
  assign bus.stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written reset
// corner case, and randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fetch_stage_if #(.CNT_W(32)) bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP),
    .CNT_W     (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Instruction memory: every word reads as 0x1000 + its address.
  assign bus.imem_data = 32'h0000_1000 + bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic [31:0] e_fetch;
    logic [31:0] e_flush;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vecs[$];

  // Reference-model state
  logic [31:0] m_pc, m_instr, m_pp4, m_fc, m_flc, m_sc;
  logic        m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pp4, input logic valid, input logic [31:0] fc,
                             input logic [31:0] flc, input logic [31:0] sc);
    check({tag, ".imem_addr"},   bus.imem_addr,      pc);
    check({tag, ".instr"},       bus.if_id_instr,    instr);
    check({tag, ".pc_plus4"},    bus.if_id_pc_plus4, pp4);
    check({tag, ".valid"},       {31'd0, bus.if_id_valid}, {31'd0, valid});
    check({tag, ".fetch_count"}, bus.fetch_count,    fc);
    check({tag, ".flush_count"}, bus.flush_count,    flc);
    check({tag, ".stall_count"}, bus.stall_count,    sc);
  endtask

  task automatic add(input logic s, input logic b, input logic [31:0] bt, input logic j,
                     input logic [31:0] jt, input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] pp4, input logic v, input logic [31:0] fc,
                     input logic [31:0] flc, input logic [31:0] sc);
    vec_t t;
    t = '{s, b, bt, j, jt, pc, ins, pp4, v, fc, flc, sc};
    vecs.push_back(t);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0;
    m_fc = 32'h0; m_flc = 32'h0; m_sc = 32'h0;
  endtask

  // One clock edge as the priority rules describe it.
  task automatic model_edge(input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt);
    logic [31:0] next4;
    next4 = m_pc + 32'd4;
    if (s) begin
      m_sc = m_sc + 1;
    end else if (b || j) begin
      m_pc    = (b ? bt : jt) & 32'hFFFF_FFFC;
      m_instr = NOP;
      m_pp4   = next4;
      m_valid = 1'b0;
      m_flc   = m_flc + 1;
    end else begin
      m_instr = 32'h0000_1000 + m_pc;
      m_pp4   = next4;
      m_pc    = next4;
      m_valid = 1'b1;
      m_fc    = m_fc + 1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    #2;
    check_state("reset", 32'h0, NOP, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    reset = 1'b0;

    //   stall br  br_tgt        jmp jmp_tgt       pc            instr         pp4           v   fc flc sc
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     32'h4,        32'h1000,     32'h4,        1, 1, 0, 0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     32'h8,        32'h1004,     32'h8,        1, 2, 0, 0);
    add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,     32'h8,        32'h1004,     32'h8,        1, 2, 0, 1);
    add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,     32'h8,        32'h1004,     32'h8,        1, 2, 0, 2);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     32'hC,        32'h1008,     32'hC,        1, 3, 0, 2);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     32'h10,       32'h100C,     32'h10,       1, 4, 0, 2);
    add(1'b0, 1'b1, 32'h40,       1'b0, 32'h0,     32'h40,       NOP,          32'h14,       0, 4, 1, 2);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     32'h44,       32'h1040,     32'h44,       1, 5, 1, 2);
    add(1'b1, 1'b1, 32'h99,       1'b1, 32'h300,   32'h44,       32'h1040,     32'h44,       1, 5, 1, 3);
    add(1'b0, 1'b1, 32'h80,       1'b1, 32'h200,   32'h80,       NOP,          32'h48,       0, 5, 2, 3);
    add(1'b0, 1'b0, 32'h0,        1'b1, 32'h200,   32'h200,      NOP,          32'h84,       0, 5, 3, 3);
    add(1'b0, 1'b1, 32'hFFFF_FFFC,1'b0, 32'h0,     32'hFFFF_FFFC,NOP,          32'h204,      0, 5, 4, 3);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     32'h0,        32'h0000_0FFC,32'h0,        1, 6, 4, 3);
    add(1'b0, 1'b1, 32'h43,       1'b0, 32'h0,     32'h40,       NOP,          32'h4,        0, 6, 5, 3);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     32'h44,       32'h1040,     32'h44,       1, 7, 5, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].stall, vecs[i].br, vecs[i].br_tgt, vecs[i].jmp, vecs[i].jmp_tgt);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4,
                  vecs[i].e_valid, vecs[i].e_fetch, vecs[i].e_flush, vecs[i].e_stall);
      check($sformatf("vec%0d.count_sum", i),
            bus.fetch_count + bus.flush_count + bus.stall_count, i + 1);
    end

    // Reset asserted mid-cycle while stalled takes effect without a clock edge.
    set_in(1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    step();
    #3;
    reset = 1'b1;
    #1;
    check_state("midreset", 32'h0, NOP, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    check_state("reset_held", 32'h0, NOP, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_state("resume", 32'h4, 32'h1000, 32'h4, 1'b1, 32'h1, 32'h0, 32'h0);

    // Randomized traffic against the model, with occasional async reset pulses.
    apply_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic s, b, j;
      logic [31:0] bt, jt;
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      j  = ($urandom_range(0, 7) == 0);
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
      end
      set_in(s, b, bt, j, jt);
      step();
      model_edge(s, b, bt, j, jt);
      check_state($sformatf("rand%0d", n), m_pc, m_instr, m_pp4, m_valid, m_fc, m_flc, m_sc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
